// File: rtl/cc_datapath_sequencer.sv
// ============================================================================
// Module   : cc_datapath_sequencer
// Brief    : Steps one reg-to-reg micro-op through read A, read B, ALU wait
//            and writeback on the uDATAPATH mux, operand latches and RF port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_datapath_sequencer #(
    parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
    parameter int DATAWIDTH_MIR_SELECTION        = 6,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int ALU_LATENCY                    = 2
) (
    input  logic                                      CC_DATAPATH_SEQUENCER_CLOCK_50,
    input  logic                                      CC_DATAPATH_SEQUENCER_RESET_InHigh,
    input  logic                                      CC_DATAPATH_SEQUENCER_Start_In,
    input  logic                                      CC_DATAPATH_SEQUENCER_Abort_In,
    input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_DATAPATH_SEQUENCER_Rs1_InBus,
    input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_DATAPATH_SEQUENCER_Rs2_InBus,
    input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_DATAPATH_SEQUENCER_Rd_InBus,
    input  logic                                      CC_DATAPATH_SEQUENCER_UseImm_In,
    input  logic [DATAWIDTH_MIR_SELECTION-1:0]        CC_DATAPATH_SEQUENCER_MIRConst_InBus,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]        CC_DATAPATH_SEQUENCER_ALUOp_InBus,
    output logic                                      CC_DATAPATH_SEQUENCER_MuxSelect_Out,
    output logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_DATAPATH_SEQUENCER_ScratchpadSelection_OutBus,
    output logic [DATAWIDTH_MIR_SELECTION-1:0]        CC_DATAPATH_SEQUENCER_MIRSelection_OutBus,
    output logic                                      CC_DATAPATH_SEQUENCER_LoadA_Out,
    output logic                                      CC_DATAPATH_SEQUENCER_LoadB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        CC_DATAPATH_SEQUENCER_ALUOp_OutBus,
    output logic                                      CC_DATAPATH_SEQUENCER_RegWrite_Out,
    output logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_DATAPATH_SEQUENCER_WriteAddress_OutBus,
    output logic                                      CC_DATAPATH_SEQUENCER_Busy_Out,
    output logic                                      CC_DATAPATH_SEQUENCER_Done_Out
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_READ_A = 3'd1;
    localparam logic [2:0] c_S_READ_B = 3'd2;
    localparam logic [2:0] c_S_EXEC   = 3'd3;
    localparam logic [2:0] c_S_WRITE  = 3'd4;

    localparam logic [3:0] c_EXEC_LAST = 4'(ALU_LATENCY - 1);

    logic [2:0]                                r_state;
    logic [2:0]                                w_nextState;
    logic [3:0]                                r_count;
    logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] r_rs1;
    logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] r_rs2;
    logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] r_rd;
    logic                                      r_useImm;
    logic [DATAWIDTH_MIR_SELECTION-1:0]        r_mirConst;
    logic [DATAWIDTH_ALU_SELECTION-1:0]        r_aluOp;

    always_ff @(posedge CC_DATAPATH_SEQUENCER_CLOCK_50) begin
        if (CC_DATAPATH_SEQUENCER_RESET_InHigh) begin
            r_state    <= c_S_IDLE;
            r_count    <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_useImm   <= 1'b0;
            r_mirConst <= '0;
            r_aluOp    <= '0;
        end else begin
            r_state <= w_nextState;
            // Counter restarts whenever EXEC is left or not yet entered.
            if (r_state == c_S_EXEC && w_nextState == c_S_EXEC) begin
                r_count <= r_count + 4'd1;
            end else begin
                r_count <= '0;
            end
            if (r_state == c_S_IDLE && CC_DATAPATH_SEQUENCER_Start_In) begin
                r_rs1      <= CC_DATAPATH_SEQUENCER_Rs1_InBus;
                r_rs2      <= CC_DATAPATH_SEQUENCER_Rs2_InBus;
                r_rd       <= CC_DATAPATH_SEQUENCER_Rd_InBus;
                r_useImm   <= CC_DATAPATH_SEQUENCER_UseImm_In;
                r_mirConst <= CC_DATAPATH_SEQUENCER_MIRConst_InBus;
                r_aluOp    <= CC_DATAPATH_SEQUENCER_ALUOp_InBus;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE:   if (CC_DATAPATH_SEQUENCER_Start_In) w_nextState = c_S_READ_A;
            c_S_READ_A: w_nextState = CC_DATAPATH_SEQUENCER_Abort_In ? c_S_IDLE : c_S_READ_B;
            c_S_READ_B: w_nextState = CC_DATAPATH_SEQUENCER_Abort_In ? c_S_IDLE : c_S_EXEC;
            c_S_EXEC: begin
                if (CC_DATAPATH_SEQUENCER_Abort_In) begin
                    w_nextState = c_S_IDLE;
                end else if (r_count == c_EXEC_LAST) begin
                    w_nextState = c_S_WRITE;
                end
            end
            c_S_WRITE:  w_nextState = c_S_IDLE;
            default:    w_nextState = c_S_IDLE;
        endcase
    end

    always_comb begin
        CC_DATAPATH_SEQUENCER_MuxSelect_Out              = 1'b0;
        CC_DATAPATH_SEQUENCER_ScratchpadSelection_OutBus = '0;
        CC_DATAPATH_SEQUENCER_MIRSelection_OutBus        = '0;
        CC_DATAPATH_SEQUENCER_LoadA_Out                  = 1'b0;
        CC_DATAPATH_SEQUENCER_LoadB_Out                  = 1'b0;
        CC_DATAPATH_SEQUENCER_ALUOp_OutBus               = '0;
        CC_DATAPATH_SEQUENCER_RegWrite_Out               = 1'b0;
        CC_DATAPATH_SEQUENCER_WriteAddress_OutBus        = '0;
        CC_DATAPATH_SEQUENCER_Busy_Out                   = (r_state != c_S_IDLE);
        CC_DATAPATH_SEQUENCER_Done_Out                   = 1'b0;
        case (r_state)
            c_S_READ_A: begin
                CC_DATAPATH_SEQUENCER_ScratchpadSelection_OutBus = r_rs1;
                CC_DATAPATH_SEQUENCER_LoadA_Out                  = 1'b1;
            end
            c_S_READ_B: begin
                CC_DATAPATH_SEQUENCER_LoadB_Out = 1'b1;
                if (r_useImm) begin
                    CC_DATAPATH_SEQUENCER_MuxSelect_Out       = 1'b1;
                    CC_DATAPATH_SEQUENCER_MIRSelection_OutBus = r_mirConst;
                end else begin
                    CC_DATAPATH_SEQUENCER_ScratchpadSelection_OutBus = r_rs2;
                end
            end
            c_S_EXEC: begin
                CC_DATAPATH_SEQUENCER_ALUOp_OutBus = r_aluOp;
            end
            c_S_WRITE: begin
                // Register 0 reads as zero, so writing it is suppressed.
                CC_DATAPATH_SEQUENCER_ALUOp_OutBus        = r_aluOp;
                CC_DATAPATH_SEQUENCER_WriteAddress_OutBus = r_rd;
                CC_DATAPATH_SEQUENCER_RegWrite_Out        = (r_rd != '0);
                CC_DATAPATH_SEQUENCER_Done_Out            = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cc_datapath_sequencer.sv
// ============================================================================
// Module   : tb_cc_datapath_sequencer
// Brief    : Self-checking bench; expected outputs come from each operation's
//            cycle position (k = 0 read A, 1 read B, EXEC, then WRITE).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_datapath_sequencer;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       useImm;
    logic [5:0] mirConst;
    logic [3:0] aluOp;

    logic       muxSel;
    logic [4:0] spSel;
    logic [5:0] mirSel;
    logic       loadA;
    logic       loadB;
    logic [3:0] aluOut;
    logic       regWrite;
    logic [4:0] wAddr;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cc_datapath_sequencer #(
        .DATAWIDTH_SCRATCHPAD_SELECTION(5),
        .DATAWIDTH_MIR_SELECTION(6),
        .DATAWIDTH_ALU_SELECTION(4),
        .ALU_LATENCY(L)
    ) dut (
        .CC_DATAPATH_SEQUENCER_CLOCK_50(clk),
        .CC_DATAPATH_SEQUENCER_RESET_InHigh(rst),
        .CC_DATAPATH_SEQUENCER_Start_In(start),
        .CC_DATAPATH_SEQUENCER_Abort_In(abort),
        .CC_DATAPATH_SEQUENCER_Rs1_InBus(rs1),
        .CC_DATAPATH_SEQUENCER_Rs2_InBus(rs2),
        .CC_DATAPATH_SEQUENCER_Rd_InBus(rd),
        .CC_DATAPATH_SEQUENCER_UseImm_In(useImm),
        .CC_DATAPATH_SEQUENCER_MIRConst_InBus(mirConst),
        .CC_DATAPATH_SEQUENCER_ALUOp_InBus(aluOp),
        .CC_DATAPATH_SEQUENCER_MuxSelect_Out(muxSel),
        .CC_DATAPATH_SEQUENCER_ScratchpadSelection_OutBus(spSel),
        .CC_DATAPATH_SEQUENCER_MIRSelection_OutBus(mirSel),
        .CC_DATAPATH_SEQUENCER_LoadA_Out(loadA),
        .CC_DATAPATH_SEQUENCER_LoadB_Out(loadB),
        .CC_DATAPATH_SEQUENCER_ALUOp_OutBus(aluOut),
        .CC_DATAPATH_SEQUENCER_RegWrite_Out(regWrite),
        .CC_DATAPATH_SEQUENCER_WriteAddress_OutBus(wAddr),
        .CC_DATAPATH_SEQUENCER_Busy_Out(busy),
        .CC_DATAPATH_SEQUENCER_Done_Out(done)
    );

    wire [25:0] obs = {muxSel, spSel, mirSel, loadA, loadB, aluOut, regWrite, wAddr, busy, done};

    // Accepted request fields as seen by the reference model.
    logic [4:0] mRs1, mRs2, mRd;
    logic       mImm;
    logic [5:0] mMir;
    logic [3:0] mOp;

    // k is the cycle index since acceptance; anything outside 0..L+2 is idle.
    function automatic logic [25:0] expVec(int k);
        logic       mx = 1'b0;
        logic [4:0] sp = '0;
        logic [5:0] mi = '0;
        logic       la = 1'b0;
        logic       lb = 1'b0;
        logic [3:0] op = '0;
        logic       rw = 1'b0;
        logic [4:0] wa = '0;
        logic       bz = 1'b0;
        logic       dn = 1'b0;
        if (k == 0) begin
            sp = mRs1; la = 1'b1; bz = 1'b1;
        end else if (k == 1) begin
            lb = 1'b1; bz = 1'b1;
            if (mImm) begin mx = 1'b1; mi = mMir; end
            else sp = mRs2;
        end else if (k >= 2 && k <= L + 1) begin
            op = mOp; bz = 1'b1;
        end else if (k == L + 2) begin
            op = mOp; wa = mRd; rw = (mRd != 5'd0); dn = 1'b1; bz = 1'b1;
        end
        return {mx, sp, mi, la, lb, op, rw, wa, bz, dn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randInputs();
        rs1      = 5'($urandom);
        rs2      = 5'($urandom);
        rd       = 5'($urandom);
        useImm   = 1'($urandom);
        mirConst = 6'($urandom);
        aluOp    = 4'($urandom);
    endtask

    task automatic setInputs(input logic [4:0] a, b, d, input logic u,
                             input logic [5:0] m, input logic [3:0] o);
        rs1 = a; rs2 = b; rd = d; useImm = u; mirConst = m; aluOp = o;
    endtask

    task automatic captureModel();
        mRs1 = rs1; mRs2 = rs2; mRd = rd; mImm = useImm; mMir = mirConst; mOp = aluOp;
    endtask

    // Accepts the request currently on the inputs and walks it to IDLE.
    // abortAt >= 0 raises Abort during that cycle index.
    task automatic runOp(input string name, input int abortAt, input bit noise);
        captureModel();
        start = 1'b1;
        step();
        for (int k = 0; k <= L + 2; k++) begin
            checks++;
            if (obs !== expVec(k)) begin
                failures++;
                $display("FAIL %s k=%0d got=%h exp=%h", name, k, obs, expVec(k));
            end
            start = 1'b0;
            if (noise) begin
                randInputs();
                if (k < L + 2) start = 1'($urandom);
            end
            if (k == abortAt) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                break;
            end
            step();
        end
        checks++;
        if (obs !== expVec(-1)) begin
            failures++;
            $display("FAIL %s_idle got=%h exp=%h", name, obs, expVec(-1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        randInputs();
        step(); step();
        checks++;
        if (obs !== 26'd0) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs, 26'd0);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        setInputs(5'd3, 5'd7, 5'd9, 1'b0, 6'd0, 4'h2);
        runOp("basic", -1, 1'b1);
    endtask

    task automatic test_mir();
        setInputs(5'd12, 5'd21, 5'd5, 1'b1, 6'd37, 4'hA);
        runOp("mir", -1, 1'b1);
    endtask

    task automatic test_rd0();
        int rwSeen = 0;
        int doneSeen = 0;
        setInputs(5'd4, 5'd6, 5'd0, 1'b0, 6'd1, 4'h7);
        captureModel();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= L + 2; k++) begin
            checks++;
            if (obs !== expVec(k)) begin
                failures++;
                $display("FAIL rd0 k=%0d got=%h exp=%h", k, obs, expVec(k));
            end
            rwSeen   += int'(regWrite);
            doneSeen += int'(done);
            step();
        end
        checks++;
        if (rwSeen != 0 || doneSeen != 1) begin
            failures++;
            $display("FAIL rd0_counts regWrite=%0d done=%0d exp 0 and 1", rwSeen, doneSeen);
        end
    endtask

    task automatic test_abort();
        setInputs(5'd1, 5'd2, 5'd3, 1'b0, 6'd0, 4'h5);
        runOp("abort_exec0", 2, 1'b1);
        setInputs(5'd8, 5'd9, 5'd10, 1'b1, 6'd11, 4'h3);
        runOp("abort_readA", 0, 1'b0);
        setInputs(5'd13, 5'd14, 5'd15, 1'b1, 6'd16, 4'h4);
        runOp("abort_readB", 1, 1'b0);
        // Abort during WRITE must not cancel the write
        setInputs(5'd17, 5'd18, 5'd19, 1'b0, 6'd20, 4'h6);
        runOp("abort_write", L + 2, 1'b0);
        // Start beats Abort in IDLE
        abort = 1'b1;
        setInputs(5'd22, 5'd23, 5'd24, 1'b0, 6'd25, 4'h8);
        captureModel();
        start = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (obs !== expVec(0)) begin
            failures++;
            $display("FAIL idle_start_abort got=%h exp=%h", obs, expVec(0));
        end
        for (int k = 0; k < L + 3; k++) step();
    endtask

    task automatic test_back_to_back();
        int lastDone = -1;
        int cyc = 0;
        randInputs();
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            captureModel();
            step(); cyc++;
            for (int k = 0; k <= L + 2; k++) begin
                checks++;
                if (obs !== expVec(k)) begin
                    failures++;
                    $display("FAIL b2b op=%0d k=%0d got=%h exp=%h", op, k, obs, expVec(k));
                end
                if (done) begin
                    if (lastDone >= 0) begin
                        checks++;
                        if (cyc - lastDone != L + 4) begin
                            failures++;
                            $display("FAIL b2b_period got=%0d exp=%0d", cyc - lastDone, L + 4);
                        end
                    end
                    lastDone = cyc;
                end
                randInputs();
                step(); cyc++;
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle op=%0d busy got=%b exp=0", op, busy);
            end
            if (op < 2) randInputs();
            else start = 1'b0;
        end
        step();
    endtask

    task automatic test_reset_mid();
        setInputs(5'd30, 5'd31, 5'd29, 1'b1, 6'd63, 4'hF);
        start = 1'b1;
        step(); start = 1'b0;
        step();
        checks++;
        if (loadB !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_readB loadB got=%b exp=1", loadB);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== 26'd0) begin
            failures++;
            $display("FAIL rstmid got=%h exp=%h", obs, 26'd0);
        end
        setInputs(5'd2, 5'd4, 5'd6, 1'b0, 6'd8, 4'h1);
        runOp("after_rst", -1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int ab;
            randInputs();
            if (i % 7 == 0) rd = 5'd0;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L + 2)) : -1;
            runOp("random", ab, 1'b1);
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        setInputs('0, '0, '0, 1'b0, '0, '0);
        test_reset();
        test_basic();
        test_mir();
        test_rd0();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
